// File: rtl/mem_bus_pkg.sv
// Shared types for the CPU memory responder: region tags, map constants, address decode.
// No logic of its own; imported by mem_bus and oam_dma.
package mem_bus_pkg;

    typedef enum logic [2:0] {
        REG_ROM,
        REG_WRAM,
        REG_ECHO,
        REG_OAM,
        REG_HRAM,
        REG_DMA,
        REG_IE,
        REG_UNMAPPED
    } region_e;

    localparam logic [15:0] ROM_LIMIT    = 16'h7FFF;
    localparam logic [15:0] WRAM_BASE    = 16'hC000;
    localparam logic [15:0] WRAM_LIMIT   = 16'hDFFF;
    localparam logic [15:0] ECHO_BASE    = 16'hE000;
    localparam logic [15:0] ECHO_LIMIT   = 16'hFDFF;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [15:0] OAM_LIMIT    = 16'hFE9F;
    localparam logic [15:0] HRAM_BASE    = 16'hFF80;
    localparam logic [15:0] HRAM_LIMIT   = 16'hFFFE;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] IE_ADDR      = 16'hFFFF;

    localparam int WRAM_SIZE = 8192;
    localparam int OAM_SIZE  = 160;
    localparam int HRAM_SIZE = 127;

    // Request bundle from the DMA engine to the bus mux.
    typedef struct packed {
        logic        src_rd_vld;
        logic [15:0] src_rd_addr;
        logic        oam_wr_vld;
        logic [7:0]  oam_wr_idx;
    } dma_req_t;

    function automatic region_e decode_region(input logic [15:0] addr);
        region_e r;
        r = REG_UNMAPPED;
        if (addr <= ROM_LIMIT)                               r = REG_ROM;
        else if (addr >= WRAM_BASE && addr <= WRAM_LIMIT)    r = REG_WRAM;
        else if (addr >= ECHO_BASE && addr <= ECHO_LIMIT)    r = REG_ECHO;
        else if (addr >= OAM_BASE && addr <= OAM_LIMIT)      r = REG_OAM;
        else if (addr == DMA_REG_ADDR)                       r = REG_DMA;
        else if (addr >= HRAM_BASE && addr <= HRAM_LIMIT)    r = REG_HRAM;
        else if (addr == IE_ADDR)                            r = REG_IE;
        return r;
    endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: copies DMA_LEN bytes from {src_hi, idx} into OAM, one byte per slot.
// Latency: source read on slot 0, OAM write on slot 1; DMA_SLOT_CLKS*DMA_LEN clocks per run.
// Backpressure: none; a new start always wins and restarts the copy from byte 0.
module oam_dma
    import mem_bus_pkg::*;
#(
    parameter int DMA_SLOT_CLKS = 4,
    parameter int DMA_LEN       = 160
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       start_vld,
    input  logic [7:0] start_dat,
    output logic       dma_active,
    output dma_req_t   dma_req
);

    localparam int SLOT_W = $clog2(DMA_SLOT_CLKS + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DMA_SLOT_CLKS - 1);
    localparam logic [7:0]        LAST_IDX  = 8'(DMA_LEN - 1);

    typedef enum logic {IDLE, RUN} dma_state_e;

    dma_state_e        state_q, state_d;
    logic [7:0]        src_hi_q, src_hi_d;
    logic [7:0]        byte_idx_q, byte_idx_d;
    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            src_hi_q   <= 8'hFF;
            byte_idx_q <= '0;
            slot_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            src_hi_q   <= src_hi_d;
            byte_idx_q <= byte_idx_d;
            slot_cnt_q <= slot_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        src_hi_d   = src_hi_q;
        byte_idx_d = byte_idx_q;
        slot_cnt_d = slot_cnt_q;
        if (start_vld) begin
            state_d    = RUN;
            src_hi_d   = start_dat;
            byte_idx_d = '0;
            slot_cnt_d = '0;
        end else if (state_q == RUN) begin
            if (slot_cnt_q == SLOT_LAST) begin
                slot_cnt_d = '0;
                if (byte_idx_q == LAST_IDX) state_d = IDLE;
                else                        byte_idx_d = byte_idx_q + 8'd1;
            end else begin
                slot_cnt_d = slot_cnt_q + 1'b1;
            end
        end
    end

    // src_hi doubles as the readable DMA register value.
    assign dma_active          = (state_q == RUN);
    assign dma_req.src_rd_vld  = dma_active && (slot_cnt_q == '0);
    assign dma_req.src_rd_addr = {src_hi_q, byte_idx_q};
    assign dma_req.oam_wr_vld  = dma_active && (slot_cnt_q == SLOT_W'(1));
    assign dma_req.oam_wr_idx  = byte_idx_q;

endmodule

// File: rtl/mem_bus.sv
// CPU memory responder with OAM DMA; MEM_BUS_ECHO_RAM_EN maps E000-FDFF onto WRAM.
// Latency: read data one clock after the address is sampled; writes commit on the sampling edge.
// Backpressure: none; during DMA blocked reads return UNMAPPED_VAL and blocked writes are dropped.
module mem_bus
    import mem_bus_pkg::*;
#(
    parameter int         DMA_SLOT_CLKS = 4,
    parameter int         DMA_LEN       = 160,
    parameter logic [7:0] UNMAPPED_VAL  = 8'hFF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_mem_rd_addr,
    output logic [7:0]  o_mem_rd_data,
    input  logic        i_mem_wr_en,
    input  logic [15:0] i_mem_wr_addr,
    input  logic [7:0]  i_mem_wr_data,
    output logic [14:0] o_rom_rd_addr,
    input  logic [7:0]  i_rom_rd_data,
    output logic        o_dma_active
);

`ifdef MEM_BUS_ECHO_RAM_EN
    localparam bit ECHO_EN = 1'b1;
`else
    localparam bit ECHO_EN = 1'b0;
`endif

    logic [7:0] wram [0:WRAM_SIZE-1];
    logic [7:0] oam  [0:OAM_SIZE-1];
    logic [7:0] hram [0:HRAM_SIZE-1];

    logic       dma_active;
    dma_req_t   dma_req;
    logic       wr_go;
    logic       dma_start_vld;
    logic [7:0] dma_reg;
    logic [7:0] ie_q;
    region_e    rd_reg, rd_reg_q, wr_reg, src_reg, src_reg_q;
    logic [7:0] rd_dat, rd_dat_q, src_dat, src_dat_q, dma_byte;

    function automatic region_e map_region(input logic [15:0] addr);
        region_e r;
        r = decode_region(addr);
        if (!ECHO_EN && r == REG_ECHO) r = REG_UNMAPPED;
        return r;
    endfunction

    function automatic logic cpu_ok_in_dma(input region_e r);
        return (r == REG_HRAM) || (r == REG_DMA) || (r == REG_IE);
    endfunction

    always_comb begin
        rd_reg = map_region(i_mem_rd_addr);
        if (dma_active && !cpu_ok_in_dma(rd_reg)) rd_reg = REG_UNMAPPED;
        wr_reg = map_region(i_mem_wr_addr);
        if (dma_active && !cpu_ok_in_dma(wr_reg)) wr_reg = REG_UNMAPPED;
        // The DMA may only pull from ROM and WRAM (or its echo).
        src_reg = map_region(dma_req.src_rd_addr);
        if (!(src_reg inside {REG_ROM, REG_WRAM, REG_ECHO})) src_reg = REG_UNMAPPED;
    end

    always_comb begin
        rd_dat = UNMAPPED_VAL;
        case (rd_reg)
            REG_WRAM, REG_ECHO: rd_dat = wram[i_mem_rd_addr[12:0]];
            REG_OAM:            rd_dat = oam[i_mem_rd_addr[7:0]];
            REG_HRAM:           rd_dat = hram[i_mem_rd_addr[6:0]];
            REG_DMA:            rd_dat = dma_reg;
            REG_IE:             rd_dat = ie_q;
            default:            rd_dat = UNMAPPED_VAL;
        endcase
    end

    assign src_dat = (src_reg == REG_WRAM || src_reg == REG_ECHO) ?
                     wram[dma_req.src_rd_addr[12:0]] : UNMAPPED_VAL;

    assign wr_go         = i_mem_wr_en && !i_rst;
    assign dma_start_vld = wr_go && (wr_reg == REG_DMA);
    assign dma_reg       = dma_req.src_rd_addr[15:8];

    oam_dma #(
        .DMA_SLOT_CLKS (DMA_SLOT_CLKS),
        .DMA_LEN       (DMA_LEN)
    ) u_oam_dma (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .start_vld  (dma_start_vld),
        .start_dat  (i_mem_wr_data),
        .dma_active (dma_active),
        .dma_req    (dma_req)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_reg_q <= REG_UNMAPPED;
            rd_dat_q <= UNMAPPED_VAL;
            ie_q     <= 8'h00;
        end else begin
            rd_reg_q <= rd_reg;
            rd_dat_q <= rd_dat;
            if (wr_go && wr_reg == REG_IE) ie_q <= i_mem_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (dma_req.src_rd_vld) begin
            src_reg_q <= src_reg;
            src_dat_q <= src_dat;
        end
    end

    assign dma_byte = (src_reg_q == REG_ROM) ? i_rom_rd_data : src_dat_q;

    always_ff @(posedge i_clk) begin
        if (wr_go && (wr_reg == REG_WRAM || wr_reg == REG_ECHO))
            wram[i_mem_wr_addr[12:0]] <= i_mem_wr_data;
        if (wr_go && wr_reg == REG_HRAM)
            hram[i_mem_wr_addr[6:0]] <= i_mem_wr_data;
        if (!i_rst && dma_req.oam_wr_vld)
            oam[dma_req.oam_wr_idx] <= dma_byte;
        else if (wr_go && wr_reg == REG_OAM)
            oam[i_mem_wr_addr[7:0]] <= i_mem_wr_data;
    end

    assign o_rom_rd_addr = dma_active ? dma_req.src_rd_addr[14:0] : i_mem_rd_addr[14:0];
    assign o_mem_rd_data = (rd_reg_q == REG_ROM) ? i_rom_rd_data : rd_dat_q;
    assign o_dma_active  = dma_active;

endmodule

// File: tb/tb_mem_bus.sv
// Bench for mem_bus: directed sequence plus randomized CPU traffic checked against
// a flat 64 KiB reference memory with address-map rules and DMA timing from cycle counts.
module tb_mem_bus;

`ifdef MEM_BUS_ECHO_RAM_EN
    localparam bit ECHO_EN = 1'b1;
`else
    localparam bit ECHO_EN = 1'b0;
`endif
    localparam int DMA_CLKS = 640;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [15:0] i_mem_rd_addr;
    logic [7:0]  o_mem_rd_data;
    logic        i_mem_wr_en;
    logic [15:0] i_mem_wr_addr;
    logic [7:0]  i_mem_wr_data;
    logic [14:0] o_rom_rd_addr;
    logic [7:0]  i_rom_rd_data;
    logic        o_dma_active;

    mem_bus dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_mem_rd_addr (i_mem_rd_addr),
        .o_mem_rd_data (o_mem_rd_data),
        .i_mem_wr_en   (i_mem_wr_en),
        .i_mem_wr_addr (i_mem_wr_addr),
        .i_mem_wr_data (i_mem_wr_data),
        .o_rom_rd_addr (o_rom_rd_addr),
        .i_rom_rd_data (i_rom_rd_data),
        .o_dma_active  (o_dma_active)
    );

    always #5 i_clk = ~i_clk;

    logic [7:0] rom_mem [0:32767];
    always @(posedge i_clk) i_rom_rd_data <= rom_mem[o_rom_rd_addr];

    logic [7:0] ref_mem [0:65535];
    int         cyc = 0;
    int         dma_start = 0;
    int         dma_end = 0;
    bit         dma_pend = 1'b0;
    bit         oam_known = 1'b0;
    logic [7:0] dma_src = 8'h00;
    int         checks = 0;
    int         errors = 0;

    function automatic logic [7:0] ref_byte(input logic [15:0] a, input bit dma_rd);
        if (a < 16'h8000) return rom_mem[a[14:0]];
        if (a >= 16'hC000 && a < 16'hE000) return ref_mem[a];
        if (a >= 16'hE000 && a < 16'hFE00) return ECHO_EN ? ref_mem[a - 16'h2000] : 8'hFF;
        if (dma_rd) return 8'hFF;
        if ((a >= 16'hFE00 && a < 16'hFEA0) || a == 16'hFF46 || a >= 16'hFF80) return ref_mem[a];
        return 8'hFF;
    endfunction

    function automatic void ref_write(input logic [15:0] a, input logic [7:0] d);
        if (a >= 16'hC000 && a < 16'hE000) ref_mem[a] = d;
        else if (a >= 16'hE000 && a < 16'hFE00) begin
            if (ECHO_EN) ref_mem[a - 16'h2000] = d;
        end else if ((a >= 16'hFE00 && a < 16'hFEA0) || a == 16'hFF46 || a >= 16'hFF80)
            ref_mem[a] = d;
    endfunction

    function automatic bit dma_ok(input logic [15:0] a);
        return (a >= 16'hFF80) || (a == 16'hFF46);
    endfunction

    function automatic void model_dma(input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] lo;
            lo = 8'(i);
            ref_mem[16'hFE00 + 16'(i)] = ref_byte({dma_src, lo}, 1'b1);
        end
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        cyc++;
        if (dma_pend && cyc == dma_end) begin
            model_dma(160);
            dma_pend = 1'b0;
        end
        chk("dma_active", {15'd0, o_dma_active}, {15'd0, (cyc < dma_end)});
    endtask

    task automatic step(input logic [15:0] ra, input bit we, input logic [15:0] wa,
                        input logic [7:0] wd, input bit do_chk, input string tag);
        bit         busy;
        logic [7:0] exp;
        busy = (cyc < dma_end);
        exp  = (busy && !dma_ok(ra)) ? 8'hFF : ref_byte(ra, 1'b0);
        i_mem_rd_addr = ra;
        i_mem_wr_en   = we;
        i_mem_wr_addr = wa;
        i_mem_wr_data = wd;
        if (we && (!busy || dma_ok(wa))) begin
            ref_write(wa, wd);
            if (wa == 16'hFF46) begin
                dma_src   = wd;
                dma_start = cyc + 1;
                dma_end   = cyc + 1 + DMA_CLKS;
                dma_pend  = 1'b1;
            end
        end
        tick();
        i_mem_wr_en = 1'b0;
        if (do_chk) chk(tag, {8'h00, o_mem_rd_data}, {8'h00, exp});
    endtask

    task automatic rand_step();
        logic [15:0] ra, wa;
        bit          we;
        case ($urandom_range(0, oam_known ? 8 : 7))
            0:       ra = 16'hC000 + 16'($urandom_range(0, 16'h2FF));
            1:       ra = 16'hE000 + 16'($urandom_range(0, 16'h2FF));
            2:       ra = 16'hFF80 + 16'($urandom_range(0, 126));
            3:       ra = 16'hFF46;
            4:       ra = 16'hFFFF;
            5:       ra = 16'($urandom_range(0, 16'h7FFF));
            6:       ra = 16'h8000 + 16'($urandom_range(0, 16'h3FFF));
            7:       ra = 16'hFF00 + 16'($urandom_range(0, 16'h45));
            default: ra = 16'hFE00 + 16'($urandom_range(0, 159));
        endcase
        case ($urandom_range(0, 6))
            0:       wa = 16'hFF80 + 16'($urandom_range(0, 126));
            1:       wa = 16'hFFFF;
            2:       wa = 16'hC000 + 16'($urandom_range(0, 16'h2FF));
            3:       wa = 16'hE000 + 16'($urandom_range(0, 16'h2FF));
            4:       wa = 16'($urandom_range(0, 16'h7FFF));
            5:       wa = 16'h8000 + 16'($urandom_range(0, 16'h3FFF));
            default: wa = oam_known ? 16'hFE00 + 16'($urandom_range(0, 159)) : 16'hFF80;
        endcase
        we = ($urandom_range(0, 1) == 1);
        step(ra, we, wa, 8'($urandom), 1'b1, "rand_rd");
    endtask

    task automatic wait_dma_done();
        while (cyc < dma_end) rand_step();
    endtask

    task automatic check_oam(input string tag);
        for (int i = 0; i < 160; i++) step(16'hFE00 + 16'(i), 1'b0, 16'h0000, 8'h00, 1'b1, tag);
    endtask

    task automatic do_reset();
        int r, n;
        i_rst = 1'b1;
        if (dma_pend) begin
            r = cyc + 1;
            n = (r - dma_start - 3) / 4 + 1;
            if (r - dma_start < 3) n = 0;
            if (n > 160) n = 160;
            model_dma(n);
            dma_pend = 1'b0;
        end
        dma_end = cyc;
        ref_mem[16'hFF46] = 8'hFF;
        ref_mem[16'hFFFF] = 8'h00;
        tick();
        i_rst = 1'b0;
        chk("rst_rd_data", {8'h00, o_mem_rd_data}, 16'h00FF);
    endtask

    initial begin
        i_rst = 1'b1;
        i_mem_rd_addr = 16'h0000;
        i_mem_wr_en = 1'b0;
        i_mem_wr_addr = 16'h0000;
        i_mem_wr_data = 8'h00;
        for (int a = 0; a < 32768; a++) rom_mem[a] = 8'($urandom);
        rom_mem[15'h0150] = 8'h3E;

        tick();
        do_reset();
        step(16'hFF46, 1'b0, 16'h0000, 8'h00, 1'b1, "rst_dma_reg");
        step(16'hFFFF, 1'b0, 16'h0000, 8'h00, 1'b1, "rst_ie");

        for (int a = 16'hFF80; a <= 16'hFFFE; a++)
            step(16'h0000, 1'b1, 16'(a), 8'($urandom), 1'b0, "");
        for (int a = 16'hC000; a < 16'hC300; a++)
            step(16'h0000, 1'b1, 16'(a), (a < 16'hC100) ? 8'(a) : 8'($urandom), 1'b0, "");

        step(16'h0000, 1'b1, 16'hC123, 8'h11, 1'b0, "");
        step(16'hC123, 1'b1, 16'hC123, 8'h5A, 1'b1, "rbw_old");
        step(16'hC123, 1'b0, 16'h0000, 8'h00, 1'b1, "wram_rd");

        i_mem_rd_addr = 16'h0150;
        #1;
        chk("rom_addr", {1'b0, o_rom_rd_addr}, 16'h0150);
        step(16'h0150, 1'b0, 16'h0000, 8'h00, 1'b1, "rom_rd");
        step(16'h0150, 1'b1, 16'h0150, 8'h00, 1'b1, "rom_wr_same");
        step(16'h0150, 1'b0, 16'h0000, 8'h00, 1'b1, "rom_wr_ign");
        step(16'h9000, 1'b1, 16'h9000, 8'h12, 1'b1, "unmapped_rd");

        // Full copy from C000 with directed checks during the run.
        step(16'h0000, 1'b1, 16'hFF46, 8'hC0, 1'b0, "");
        step(16'hC000, 1'b0, 16'h0000, 8'h00, 1'b1, "dma_blk_wram");
        step(16'h0150, 1'b1, 16'hFF80, 8'h77, 1'b1, "dma_blk_rom");
        step(16'hFF80, 1'b0, 16'h0000, 8'h00, 1'b1, "dma_hram");
        step(16'hFF46, 1'b0, 16'h0000, 8'h00, 1'b1, "dma_reg_rd");
        wait_dma_done();
        oam_known = 1'b1;
        check_oam("oam_c0");

        // Restart 100 clocks into a run.
        step(16'h0000, 1'b1, 16'hFF46, 8'hC0, 1'b0, "");
        for (int k = 0; k < 99; k++) rand_step();
        step(16'h0000, 1'b1, 16'hFF46, 8'hC1, 1'b0, "");
        wait_dma_done();
        check_oam("oam_restart");

        // Reset while byte 50 is in its source-read slot.
        step(16'h0000, 1'b1, 16'hFF46, 8'hC2, 1'b0, "");
        for (int k = 0; k < 200; k++) rand_step();
        do_reset();
        step(16'hFF46, 1'b0, 16'h0000, 8'h00, 1'b1, "rst_mid_dma_reg");
        check_oam("oam_rst_mid");

        step(16'h0000, 1'b1, 16'hFF46, 8'h12, 1'b0, "");
        wait_dma_done();
        check_oam("oam_rom_src");

        step(16'h0000, 1'b1, 16'hE010, 8'hA5, 1'b0, "");
        step(16'hC010, 1'b0, 16'h0000, 8'h00, 1'b1, "echo_alias");
        step(16'hE010, 1'b0, 16'h0000, 8'h00, 1'b1, "echo_rd");

        step(16'h0000, 1'b1, 16'hFF46, 8'hE0, 1'b0, "");
        wait_dma_done();
        check_oam("oam_echo_src");

        step(16'h0000, 1'b1, 16'hFF46, 8'hFE, 1'b0, "");
        wait_dma_done();
        check_oam("oam_fe_src");

        for (int k = 0; k < 200; k++) rand_step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
